serial_rx: RTL and testbench



---
 rtl/serial_rx_pkg.sv | 32 +++
 rtl/serial_rx_sync.sv | 35 +++
 rtl/serial_rx.sv | 187 ++++++++++++++++++
 tb/tb_serial_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_pkg
// Description : Shared types and helpers for the serial_rx receiver.
//               Provides the FSM state encoding, an even-parity helper and
//               the default parameter values.
//               Optional feature macro: SERIAL_RX_PARITY_EN (adds S_PAR).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_rx_pkg;

  localparam int c_clks_per_bit_def = 16;
  localparam int c_dw_def           = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
    S_PAR     = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;

  // Bit that makes the total count of ones in {d, bit} even.
  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_sync
// Description : Two-flop synchroniser for the asynchronous serial line.
//               Both flops reset to 1 (line idle level).
// Ports       : ck   - clock, rising edge
//               nrst - synchronous active-low reset
//               i_d  - asynchronous input
//               o_q  - synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_sync (
  input  logic ck,
  input  logic nrst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge ck) begin
    if (!nrst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx
// Description : Asynchronous serial-line receiver (idle high, start low,
//               LSB-first data, optional even parity, stop high) with a
//               valid/ready output buffer.
//               Optional feature macro: SERIAL_RX_PARITY_EN
//                 defined   -> one even-parity bit before stop, perr active
//                 undefined -> start + DW data + stop, perr tied 0
// Ports       : ck   - clock, rising edge
//               nrst - synchronous active-low reset
//               i    - serial line (asynchronous, idle high)
//               q    - received word, stable while vld high
//               vld  - q holds an unconsumed word
//               rdy  - consumer accepts q when vld && rdy
//               ferr - one-cycle pulse: stop bit sampled low
//               ovr  - one-cycle pulse: good frame dropped, buffer full
//               perr - one-cycle pulse: parity mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit_def,
  parameter int DW           = c_dw_def
) (
  input  logic          ck,
  input  logic          nrst,
  input  logic          i,
  output logic [DW-1:0] q,
  output logic          vld,
  input  logic          rdy,
  output logic          ferr,
  output logic          ovr,
  output logic          perr
);

  localparam int          c_cw   = $clog2(CLKS_PER_BIT);
  localparam int          c_bw   = $clog2(DW + 1);
  localparam logic [c_cw-1:0] c_half = c_cw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cw-1:0] c_full = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [c_bw-1:0] c_last = c_bw'(DW - 1);

  logic            w_si;
  logic            r_si_prev;
  state_t          r_state;
  logic [c_cw-1:0] r_cnt;
  logic [c_bw-1:0] r_bit;
  logic [DW-1:0]   r_shift;
  // Frame outcome, registered at the stop sample and applied to the
  // output buffer one cycle later.
  logic            r_good;
  logic            r_bad;
`ifdef SERIAL_RX_PARITY_EN
  logic            r_par_bad;
  logic            r_perr_pend;
`endif

  serial_rx_sync u_sync (
    .ck   (ck),
    .nrst (nrst),
    .i_d  (i),
    .o_q  (w_si)
  );

  always_ff @(posedge ck) begin
    if (!nrst) begin
      r_si_prev   <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_good      <= 1'b0;
      r_bad       <= 1'b0;
      q           <= '0;
      vld         <= 1'b0;
      ferr        <= 1'b0;
      ovr         <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_bad   <= 1'b0;
      r_perr_pend <= 1'b0;
      perr        <= 1'b0;
`endif
    end else begin
      r_si_prev <= w_si;
      r_good    <= 1'b0;
      r_bad     <= 1'b0;
      ovr       <= 1'b0;
      ferr      <= r_bad;
`ifdef SERIAL_RX_PARITY_EN
      r_perr_pend <= 1'b0;
      perr        <= r_perr_pend;
`endif

      // Output buffer: a new word may replace one being consumed this cycle.
      if (r_good && (!vld || rdy)) begin
        q   <= r_shift;
        vld <= 1'b1;
      end else begin
        if (r_good) ovr <= 1'b1;
        if (vld && rdy) vld <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_si_prev && !w_si) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end

        S_START: begin
          if (r_cnt == c_half) begin
            r_cnt   <= '0;
            // Line back high at mid start bit: treat as a glitch.
            r_state <= w_si ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end

        S_DATA: begin
          if (r_cnt == c_full) begin
            r_cnt   <= '0;
            r_shift <= {w_si, r_shift[DW-1:1]};
            r_bit   <= r_bit + c_bw'(1);
            if (r_bit == c_last) begin
`ifdef SERIAL_RX_PARITY_EN
              r_state <= S_PAR;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        S_PAR: begin
          if (r_cnt == c_full) begin
            r_cnt     <= '0;
            r_par_bad <= even_parity(16'(r_shift)) ^ w_si;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
`endif

        S_STOP: begin
          if (r_cnt == c_full) begin
            r_cnt <= '0;
            if (w_si) begin
              r_state <= S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
              if (r_par_bad) r_perr_pend <= 1'b1;
              else           r_good      <= 1'b1;
`else
              r_good <= 1'b1;
`endif
            end else begin
              r_bad   <= 1'b1;
              r_state <= S_WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end

        S_WAIT_HI: begin
          // Absorb a break: wait for the line to return to idle.
          if (w_si) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef SERIAL_RX_PARITY_EN
  assign perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_rx
// Description : Directed self-checking bench for serial_rx
//               (CLKS_PER_BIT=8, DW=8). Parity steps are built only when
//               SERIAL_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx;

  logic       ck = 1'b0;
  logic       nrst;
  logic       i;
  logic       rdy;
  logic [7:0] q;
  logic       vld;
  logic       ferr;
  logic       ovr;
  logic       perr;

  int n_pass  = 0;
  int n_total = 0;

`ifdef SERIAL_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  always #5 ck = ~ck;

  serial_rx #(.CLKS_PER_BIT(8), .DW(8)) dut (
    .ck   (ck),
    .nrst (nrst),
    .i    (i),
    .q    (q),
    .vld  (vld),
    .rdy  (rdy),
    .ferr (ferr),
    .ovr  (ovr),
    .perr (perr)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one frame. The first edge after entry is cycle 0; returns just
  // after the stop-sample edge (cycle 78 without parity), stop bit still on
  // the line so the caller can check and start the next frame at once.
  task automatic send_frame(input logic [7:0] d, input logic stopb);
    i = 1'b0;
    tick(8);
    for (int k = 0; k < 8; k++) begin
      i = d[k];
      tick(8);
    end
`ifdef SERIAL_RX_PARITY_EN
    i = (^d) ^ bad_par;
    tick(8);
`endif
    i = stopb;
    tick(7);
  endtask

  initial begin
    // Reset state
    nrst = 1'b0;
    i    = 1'b1;
    rdy  = 1'b0;
    tick(3);
    chk("rst_vld", vld, 0);
    chk("rst_q", q, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_perr", perr, 0);
    nrst = 1'b1;
    tick(2);

    // 0xA5 with rdy=1: vld high exactly one cycle
    rdy = 1'b1;
    send_frame(8'hA5, 1'b1);
    chk("a5_vld_early", vld, 0);
    tick(1);
    chk("a5_vld", vld, 1);
    chk("a5_q", q, 8'hA5);
    chk("a5_ferr", ferr, 0);
    chk("a5_ovr", ovr, 0);
    tick(1);
    chk("a5_vld_drop", vld, 0);

    // Glitch: 3 low cycles is a false start
    tick(5);
    i = 1'b0;
    tick(3);
    i = 1'b1;
    tick(100);
    chk("glitch_vld", vld, 0);
    chk("glitch_ferr", ferr, 0);

    // Stop bit low on 0x3C, line held low, then recovery with 0x12
    send_frame(8'h3C, 1'b0);
    tick(1);
    chk("brk_ferr", ferr, 1);
    chk("brk_vld", vld, 0);
    tick(1);
    chk("brk_ferr_end", ferr, 0);
    tick(39);
    i = 1'b1;
    tick(10);
    send_frame(8'h12, 1'b1);
    tick(1);
    chk("rec_vld", vld, 1);
    chk("rec_q", q, 8'h12);
    tick(5);

    // Overrun: rdy=0, back-to-back 0x11 then 0x22
    rdy = 1'b0;
    send_frame(8'h11, 1'b1);
    tick(1);
    chk("ovr_vld1", vld, 1);
    chk("ovr_q1", q, 8'h11);
    send_frame(8'h22, 1'b1);
    tick(1);
    chk("ovr_pulse", ovr, 1);
    chk("ovr_vld2", vld, 1);
    chk("ovr_q_held", q, 8'h11);
    tick(1);
    chk("ovr_pulse_end", ovr, 0);
    rdy = 1'b1;
    tick(1);
    chk("ovr_vld_drop", vld, 0);
    chk("ovr_q_after", q, 8'h11);
    i = 1'b1;
    tick(5);

    // Reset at cycle 30 of a frame
    i = 1'b0;
    tick(30);
    nrst = 1'b0;
    tick(1);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_vld", vld, 0);
    chk("mid_rst_ferr", ferr, 0);
    i = 1'b1;
    tick(4);
    nrst = 1'b1;
    tick(70);
    chk("mid_rst_noerr", ferr, 0);
    chk("mid_rst_novld", vld, 0);
    send_frame(8'hFF, 1'b1);
    tick(1);
    chk("ff_vld", vld, 1);
    chk("ff_q", q, 8'hFF);
    chk("ff_ferr", ferr, 0);
    chk("ff_perr", perr, 0);
    tick(5);

`ifdef SERIAL_RX_PARITY_EN
    // Parity: 0x07 needs parity bit 1
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    tick(1);
    chk("par_perr", perr, 1);
    chk("par_vld", vld, 0);
    tick(1);
    chk("par_perr_end", perr, 0);
    bad_par = 1'b0;
    send_frame(8'h07, 1'b1);
    tick(1);
    chk("par_ok_vld", vld, 1);
    chk("par_ok_q", q, 8'h07);
    chk("par_ok_perr", perr, 0);
    tick(5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
